// File: rtl/cp0_intc.sv
// CP0 register file (SR/Cause/EPC/PRId) and single-level interrupt sequencer.
// Optional HWInt 2-flop synchronizer enabled by defining CP0_HWINT_SYNC_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no interrupt in service; accept when pend is seen
// ST_REQ  | accept edge just happened, IntReq high for this one cycle
// ST_SVC  | handler running with EXL set; wait for ERET or EXL clear
module cp0_intc #(
  parameter logic [31:0] PRID_VAL = 32'h0000_4D50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  HWInt,
  input  logic [31:0] PC_M,
  input  logic [4:0]  Sel_R,
  input  logic [4:0]  Sel_W,
  input  logic [31:0] Din,
  input  logic        We,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] Dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic [5:0]  ip_q, ip_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [29:0] epc_q, epc_d;
  logic        intreq_q, intreq_d;
  logic [5:0]  hw_src;
  logic        pend;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^PC_M[1:0];

`ifdef CP0_HWINT_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 6'd0;
      sync2_q <= 6'd0;
    end else begin
      sync1_q <= HWInt;
      sync2_q <= sync1_q;
    end
  end

  assign hw_src = sync2_q;
`else
  assign hw_src = HWInt;
`endif

  assign pend = (|(ip_q & im_q)) & ie_q & ~exl_q;

  always_comb begin
    state_d  = state_q;
    im_d     = im_q;
    exl_d    = exl_q;
    ie_d     = ie_q;
    epc_d    = epc_q;
    intreq_d = 1'b0;
    ip_d     = hw_src;

    if (We && (Sel_W == 5'd12)) begin
      im_d  = Din[15:10];
      exl_d = Din[1];
      ie_d  = Din[0];
    end
    if (We && (Sel_W == 5'd14)) begin
      epc_d = Din[31:2];
    end

    // Accept overrides any same-cycle MTC0 to EXL or EPC
    case (state_q)
      ST_IDLE: begin
        if (pend) begin
          state_d  = ST_REQ;
          intreq_d = 1'b1;
          exl_d    = 1'b1;
          epc_d    = PC_M[31:2];
        end
      end
      ST_REQ: state_d = ST_SVC;
      ST_SVC: begin
        if (EXLClr) begin
          exl_d = 1'b0;
        end
        if (!exl_d) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      im_q     <= 6'd0;
      ip_q     <= 6'd0;
      exl_q    <= 1'b0;
      ie_q     <= 1'b0;
      epc_q    <= 30'd0;
      intreq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      im_q     <= im_d;
      ip_q     <= ip_d;
      exl_q    <= exl_d;
      ie_q     <= ie_d;
      epc_q    <= epc_d;
      intreq_q <= intreq_d;
    end
  end

  assign IntReq = intreq_q;
  assign EPC    = {epc_q, 2'b00};

  always_comb begin
    Dout = 32'd0;
    case (Sel_R)
      5'd12:   Dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   Dout = {16'd0, ip_q, 10'd0};
      5'd14:   Dout = {epc_q, 2'b00};
      5'd15:   Dout = PRID_VAL;
      default: Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed plan steps, then random traffic
// compared every cycle against a word-level reference model.
module tb_cp0_intc;

`ifdef CP0_HWINT_SYNC_EN
  localparam int N_ACC = 4;
`else
  localparam int N_ACC = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  HWInt;
  logic [31:0] PC_M;
  logic [4:0]  Sel_R;
  logic [4:0]  Sel_W;
  logic [31:0] Din;
  logic        We;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] Dout;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_intc dut (
    .clk    (clk),
    .reset  (reset),
    .HWInt  (HWInt),
    .PC_M   (PC_M),
    .Sel_R  (Sel_R),
    .Sel_W  (Sel_W),
    .Din    (Din),
    .We     (We),
    .EXLClr (EXLClr),
    .IntReq (IntReq),
    .EPC    (EPC),
    .Dout   (Dout)
  );

  always #5 clk = ~clk;

  // Reference model: registers held as whole 32-bit words; phase 0/1/2 =
  // idle / request cycle / handler running.
  logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0;
  logic        m_intreq = 1'b0;
  int          m_phase = 0;
  logic [5:0]  m_s1 = '0, m_s2 = '0;

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4D50;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] nsr, nepc;
    logic [5:0]  hw_eff;
    bit          pend;
    if (reset) begin
      m_sr = '0; m_cause = '0; m_epc = '0; m_intreq = 1'b0;
      m_phase = 0; m_s1 = '0; m_s2 = '0;
      return;
    end
`ifdef CP0_HWINT_SYNC_EN
    hw_eff = m_s2;
    m_s2 = m_s1;
    m_s1 = HWInt;
`else
    hw_eff = HWInt;
`endif
    pend = ((m_cause[15:10] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    nsr  = m_sr;
    nepc = m_epc;
    if (We && Sel_W == 5'd12) nsr = Din & 32'h0000_FC03;
    if (We && Sel_W == 5'd14) nepc = Din & 32'hFFFF_FFFC;
    m_intreq = 1'b0;
    if (m_phase == 0) begin
      if (pend) begin
        m_phase  = 1;
        m_intreq = 1'b1;
        nsr      = nsr | 32'h2;
        nepc     = PC_M & 32'hFFFF_FFFC;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      if (EXLClr) nsr = nsr & ~32'h2;
      if (nsr[1] == 1'b0) m_phase = 0;
    end
    m_sr    = nsr;
    m_epc   = nepc;
    m_cause = {16'd0, hw_eff, 10'd0};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance model, clock DUT, compare visible outputs to model.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("intreq_model", {31'd0, IntReq}, {31'd0, m_intreq});
    check("epc_model", EPC, m_epc);
    check("dout_model", Dout, m_read(Sel_R));
  endtask

  task automatic rd(input logic [4:0] s, input string tag, input logic [31:0] exp);
    Sel_R = s;
    #1;
    check(tag, Dout, exp);
  endtask

  initial begin
    reset = 1'b1; HWInt = '0; PC_M = '0; Sel_R = 5'd12; Sel_W = '0;
    Din = '0; We = 1'b0; EXLClr = 1'b0;

    cyc(); cyc();
    reset = 1'b0;
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    rd(5'd15, "prid", 32'h0000_4D50);
    rd(5'd3,  "unmapped", 32'd0);
    check("rst_intreq", {31'd0, IntReq}, 32'd0);

    // Enable IM2/IE, then raise HWInt[0]
    We = 1'b1; Sel_W = 5'd12; Din = 32'h0000_0401;
    cyc();
    We = 1'b0; HWInt = 6'b000001; PC_M = 32'h0000_3010;
    for (int i = 1; i <= N_ACC + 1; i++) begin
      cyc();
      check("accept_timing", {31'd0, IntReq}, (i == N_ACC) ? 32'd1 : 32'd0);
    end
    check("epc_capture", EPC, 32'h0000_3010);
    rd(5'd12, "sr_exl_set", 32'h0000_0403);

    // Nested request blocked while in service
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("nest_blocked", {31'd0, IntReq}, 32'd0);
    end
    EXLClr = 1'b1;
    cyc();
    EXLClr = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_0401);
    cyc();
    check("reaccept_after_eret", {31'd0, IntReq}, 32'd1);
    cyc();

    // MTC0 EPC while in service is applied
    We = 1'b1; Sel_W = 5'd14; Din = 32'h0000_5555;
    cyc();
    We = 1'b0;
    check("svc_epc_write", EPC, 32'h0000_5554);

    HWInt = '0;
    repeat (4) cyc();
    EXLClr = 1'b1;
    cyc();
    EXLClr = 1'b0;
    cyc();
    check("idle_no_req", {31'd0, IntReq}, 32'd0);

    // Accept coincident with MTC0 EPC: PC capture wins
    HWInt = 6'b000001; PC_M = 32'h0000_3020;
    repeat (N_ACC - 1) cyc();
    We = 1'b1; Sel_W = 5'd14; Din = 32'h0000_5555;
    cyc();
    We = 1'b0;
    check("collide_intreq", {31'd0, IntReq}, 32'd1);
    check("collide_epc", EPC, 32'h0000_3020);
    cyc();

    // Reset while in service
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd(5'd12, "svc_rst_sr", 32'd0);
    check("svc_rst_epc", EPC, 32'd0);
    check("svc_rst_intreq", {31'd0, IntReq}, 32'd0);
    HWInt = '0;
    cyc();

    // Masked line
    We = 1'b1; Sel_W = 5'd12; Din = 32'h0000_0401;
    cyc();
    We = 1'b0; HWInt = 6'b000010;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("masked_no_req", {31'd0, IntReq}, 32'd0);
    end
    rd(5'd13, "masked_cause", 32'h0000_0800);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 63) == 0);
      HWInt  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (HWInt & 6'($urandom));
      PC_M   = $urandom;
      Sel_R  = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      Sel_W  = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      We     = ($urandom_range(0, 3) == 0);
      Din    = $urandom;
      if ($urandom_range(0, 1) == 1) Din[1:0] = 2'b01;
      EXLClr = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
